resul_display: RTL and testbench

Display stage downstream of the PicoBlaze adder: consumes the 8-bit `resul` byte, converts it to three BCD digits with a sequential shift-add-3 (double-dabble) engine, and time-multiplexes the digits onto a 4-anode, active-low, common-anode 7-segment display. It detects value changes on its own, so the upstream block needs no strobe.

---
 rtl/resul_display_if.sv | 26 ++
 rtl/resul_display.sv | 164 ++++++++++++++++
 tb/tb_resul_display.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/resul_display_if.sv
// Bus between the adder stage and the display stage: value in, display drive and status out.
interface resul_display_if;
    logic [7:0]  resul;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [11:0] bcd;
    logic        busy;

    // Upstream side: supplies the value, observes the display and status.
    modport master (
        output resul,
        input  seg,
        input  an,
        input  bcd,
        input  busy
    );

    // Display stage side.
    modport slave (
        input  resul,
        output seg,
        output an,
        output bcd,
        output busy
    );
endinterface

// File: rtl/resul_display.sv
// resul_display: binary byte -> 3 BCD digits (sequential double-dabble) shown on a
// multiplexed active-low common-anode 7-segment display.
// Optional macro DISP_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module resul_display #(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input logic          clk,
    input logic          reset,
    resul_display_if.slave bus
);

    localparam int unsigned RW      = $clog2(REFRESH_DIV);
    localparam logic [6:0]  SEG_BLK = 7'h7F;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state_q, state_d;
    logic [7:0]      last_val_q, last_val_d;
    logic [19:0]     shreg_q, shreg_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic [11:0]     bcd_q, bcd_d;
    logic [RW-1:0]   refresh_q, refresh_d;
    logic [1:0]      dig_idx_q, dig_idx_d;
    logic [6:0]      seg_q, seg_d;
    logic [3:0]      an_q, an_d;

    // One double-dabble step: add 3 to each BCD nibble >= 5, then shift left.
    function automatic logic [19:0] add3_shift(input logic [19:0] s);
        logic [19:0] t;
        t = s;
        for (int i = 0; i < 3; i++) begin
            if (t[8+4*i +: 4] >= 4'd5)
                t[8+4*i +: 4] = t[8+4*i +: 4] + 4'd3;
        end
        return {t[18:0], 1'b0};
    endfunction

    // Active-low segment code {g,f,e,d,c,b,a}; non-decimal nibbles are blank.
    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return SEG_BLK;
        endcase
    endfunction

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            last_val_q <= 8'h00;
            shreg_q    <= 20'h00000;
            cnt_q      <= 3'd0;
            busy_q     <= 1'b0;
            bcd_q      <= 12'h000;
            refresh_q  <= '0;
            dig_idx_q  <= 2'd0;
            seg_q      <= SEG_BLK;
            an_q       <= 4'b1111;
        end else begin
            state_q    <= state_d;
            last_val_q <= last_val_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            bcd_q      <= bcd_d;
            refresh_q  <= refresh_d;
            dig_idx_q  <= dig_idx_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
        end
    end

    // Conversion FSM: detect a new value, run 8 shift steps, publish the result.
    always_comb begin
        state_d    = state_q;
        last_val_d = last_val_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        bcd_d      = bcd_q;
        case (state_q)
            IDLE: begin
                if (bus.resul != last_val_q) begin
                    shreg_d    = {12'h000, bus.resul};
                    last_val_d = bus.resul;
                    cnt_d      = 3'd0;
                    busy_d     = 1'b1;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                shreg_d = add3_shift(shreg_q);
                cnt_d   = cnt_q + 3'd1;
                if (cnt_q == 3'd7)
                    state_d = DONE;
            end
            DONE: begin
                bcd_d   = shreg_q[19:8];
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Refresh timer: advance the lit digit 0->1->2->0 every REFRESH_DIV cycles.
    always_comb begin
        refresh_d = refresh_q + RW'(1);
        dig_idx_d = dig_idx_q;
        if (refresh_q == RW'(REFRESH_DIV - 1)) begin
            refresh_d = '0;
            dig_idx_d = (dig_idx_q == 2'd2) ? 2'd0 : dig_idx_q + 2'd1;
        end
    end

    // Digit select, optional leading-zero blanking, segment/anode decode.
    always_comb begin
        logic blank_h;
        logic blank_t;
`ifdef DISP_LEADING_ZERO_BLANK_EN
        blank_h = (bcd_q[11:8] == 4'd0);
        blank_t = (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0);
`else
        blank_h = 1'b0;
        blank_t = 1'b0;
`endif
        seg_d = SEG_BLK;
        an_d  = 4'b1111;
        case (dig_idx_q)
            2'd0: begin
                an_d  = 4'b1110;
                seg_d = seg_code(bcd_q[3:0]);
            end
            2'd1: begin
                an_d  = 4'b1101;
                seg_d = blank_t ? SEG_BLK : seg_code(bcd_q[7:4]);
            end
            2'd2: begin
                an_d  = 4'b1011;
                seg_d = blank_h ? SEG_BLK : seg_code(bcd_q[11:8]);
            end
            default: begin
                an_d  = 4'b1111;
                seg_d = SEG_BLK;
            end
        endcase
    end

    assign bus.seg  = seg_q;
    assign bus.an   = an_q;
    assign bus.bcd  = bcd_q;
    assign bus.busy = busy_q;

endmodule

// File: tb/tb_resul_display.sv
// Directed bench for resul_display: reset, conversion latency, digit scan, corner sequences.
module tb_resul_display;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;

    resul_display_if bus();

    resul_display #(.REFRESH_DIV(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef DISP_LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LZ = 7'h7F;
`else
    localparam logic [6:0] LZ = 7'h40;
`endif

    typedef struct {
        logic [7:0]  val;
        logic [11:0] exp_bcd;
        logic [6:0]  seg_h;
        logic [6:0]  seg_t;
        logic [6:0]  seg_u;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge: apply v, check busy after E0..E9 and bcd after E9.
    task automatic convert(input logic [7:0] v, input logic [11:0] e);
        bus.resul = v;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("busy", 32'(bus.busy), (i < 9) ? 32'd1 : 32'd0);
            if (i == 9) chk("bcd", 32'(bus.bcd), 32'(e));
        end
    endtask

    // Sample 16 cycles: seg must match the digit selected by an; runs last 4 cycles in order.
    task automatic check_display(input logic [6:0] h, input logic [6:0] t, input logic [6:0] u);
        logic [3:0] prev_an;
        logic [3:0] succ;
        logic [6:0] exp_seg;
        int         run;
        bit         seen;
        run  = 0;
        seen = 1'b0;
        prev_an = 4'b0000;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            case (bus.an)
                4'b1110: exp_seg = u;
                4'b1101: exp_seg = t;
                4'b1011: exp_seg = h;
                default: exp_seg = 7'h7F;
            endcase
            chk("an_legal", 32'(bus.an == 4'b1110 || bus.an == 4'b1101 || bus.an == 4'b1011), 32'd1);
            chk("seg", 32'(bus.seg), 32'(exp_seg));
            if (i == 0) begin
                prev_an = bus.an;
                run = 1;
            end else if (bus.an != prev_an) begin
                case (prev_an)
                    4'b1110: succ = 4'b1101;
                    4'b1101: succ = 4'b1011;
                    default: succ = 4'b1110;
                endcase
                chk("an_order", 32'(bus.an), 32'(succ));
                if (seen) chk("run_len", 32'(run), 32'd4);
                seen = 1'b1;
                prev_an = bus.an;
                run = 1;
            end else begin
                run++;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        vecs[0] = '{8'd255, 12'h255, 7'h24, 7'h12, 7'h12};
        vecs[1] = '{8'd100, 12'h100, 7'h79, 7'h40, 7'h40};
        vecs[2] = '{8'd9,   12'h009, LZ,    LZ,    7'h10};
        vecs[3] = '{8'd123, 12'h123, 7'h79, 7'h24, 7'h30};
        vecs[4] = '{8'd7,   12'h007, LZ,    LZ,    7'h78};
        vecs[5] = '{8'd50,  12'h050, LZ,    7'h12, 7'h40};
        vecs[6] = '{8'd0,   12'h000, LZ,    LZ,    7'h40};

        // Reset held with clock running.
        reset = 1'b0;
        bus.resul = 8'd0;
        repeat (4) begin
            @(negedge clk);
            chk("rst_seg",  32'(bus.seg),  32'h7F);
            chk("rst_an",   32'(bus.an),   32'hF);
            chk("rst_bcd",  32'(bus.bcd),  32'h000);
            chk("rst_busy", 32'(bus.busy), 32'd0);
        end

        // Release with resul == 0: units digit 0 lit, no conversion.
        reset = 1'b1;
        @(negedge clk);
        chk("first_an",  32'(bus.an),  32'hE);
        chk("first_seg", 32'(bus.seg), 32'h40);
        repeat (10) begin
            @(negedge clk);
            chk("idle_busy", 32'(bus.busy), 32'd0);
            chk("idle_bcd",  32'(bus.bcd),  32'h000);
        end

        // Table of conversions, each followed by a display scan check.
        for (int k = 0; k < 7; k++) begin
            convert(vecs[k].val, vecs[k].exp_bcd);
            check_display(vecs[k].seg_h, vecs[k].seg_t, vecs[k].seg_u);
        end

        // Back-to-back: 100 then 42 while busy; one idle cycle between pulses.
        bus.resul = 8'd100;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 1) bus.resul = 8'd42;
            chk("b2b_busy", 32'(bus.busy), (i == 9 || i == 19) ? 32'd0 : 32'd1);
            if (i == 9)  chk("b2b_bcd1", 32'(bus.bcd), 32'h100);
            if (i == 19) chk("b2b_bcd2", 32'(bus.bcd), 32'h042);
        end

        // Reset mid-conversion: partial result discarded, restart after release.
        bus.resul = 8'd200;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mid_busy", 32'(bus.busy), 32'd1);
        end
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_bcd",  32'(bus.bcd),  32'h000);
        chk("mid_rst_an",   32'(bus.an),   32'hF);
        repeat (2) begin
            @(negedge clk);
            chk("mid_rst_busy", 32'(bus.busy), 32'd0);
            chk("mid_rst_bcd",  32'(bus.bcd),  32'h000);
            chk("mid_rst_seg",  32'(bus.seg),  32'h7F);
        end
        reset = 1'b1;
        convert(8'd200, 12'h200);
        check_display(7'h24, LZ == 7'h7F ? 7'h40 : 7'h40, 7'h40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
